// File: rtl/issue_ctrl_nway.sv
// N-lane in-order issue controller: issues the longest hazard-free in-order prefix
// of a held decode bundle, with a load-latency scoreboard, flush and perf counters.
module issue_ctrl_nway #(
    parameter int unsigned LANES     = 2,
    parameter int unsigned RA_W      = 5,
    parameter int unsigned PAYLOAD_W = 32,
    parameter int unsigned LOAD_LAT  = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [LANES-1:0]            in_lane_valid,
    input  logic [LANES*RA_W-1:0]       in_rs1,
    input  logic [LANES*RA_W-1:0]       in_rs2,
    input  logic [LANES*RA_W-1:0]       in_rd,
    input  logic [LANES-1:0]            in_reg_write,
    input  logic [LANES-1:0]            in_mem_read,
    input  logic [LANES*PAYLOAD_W-1:0]  in_payload,
    input  logic                        flush,
    output logic [LANES-1:0]            iss_valid,
    output logic [LANES*RA_W-1:0]       iss_rs1,
    output logic [LANES*RA_W-1:0]       iss_rs2,
    output logic [LANES*RA_W-1:0]       iss_rd,
    output logic [LANES-1:0]            iss_reg_write,
    output logic [LANES-1:0]            iss_mem_read,
    output logic [LANES*PAYLOAD_W-1:0]  iss_payload,
    output logic [31:0]                 issued_insts,
    output logic [31:0]                 stall_cycles
);

    localparam int unsigned NREGS = 1 << RA_W;
    localparam int unsigned CNT_W = $clog2(LOAD_LAT + 1);

    logic                       hold_valid;
    logic [LANES-1:0]           pending;
    logic [LANES*RA_W-1:0]      rs1_q, rs2_q, rd_q;
    logic [LANES-1:0]           rw_q, mr_q;
    logic [LANES*PAYLOAD_W-1:0] pl_q;
    logic [CNT_W-1:0]           sb_cnt [NREGS];

    logic [NREGS-1:0]           busy;
    logic [NREGS-1:0]           load_set;
    logic [LANES-1:0]           issue;
    logic [LANES-1:0]           left;
    logic [31:0]                issue_cnt;
    logic                       accept;

    always_comb begin
        busy = '0;
        for (int r = 0; r < NREGS; r++) busy[r] = (sb_cnt[r] != '0);
    end

    // Walk lanes in order; the chain breaks at the first pending lane that cannot go.
    always_comb begin
        logic             chain;
        logic             hazard;
        logic [NREGS-1:0] wr_mask;
        logic [RA_W-1:0]  a1, a2, ad;
        issue    = '0;
        load_set = '0;
        chain    = hold_valid && !flush;
        hazard   = 1'b0;
        wr_mask  = '0;
        a1       = '0;
        a2       = '0;
        ad       = '0;
        for (int i = 0; i < LANES; i++) begin
            a1 = rs1_q[i*RA_W +: RA_W];
            a2 = rs2_q[i*RA_W +: RA_W];
            ad = rd_q[i*RA_W +: RA_W];
            // Entry 0 of busy/wr_mask is never set, so r0 never creates a hazard.
            hazard = busy[a1] | busy[a2] | wr_mask[a1] | wr_mask[a2]
                   | (rw_q[i] & (busy[ad] | wr_mask[ad]));
            if (pending[i]) begin
                issue[i] = chain && !hazard;
                chain    = issue[i];
            end
            if (issue[i] && rw_q[i] && ad != '0) wr_mask[ad]  = 1'b1;
            if (issue[i] && mr_q[i] && ad != '0) load_set[ad] = 1'b1;
        end
    end

    always_comb begin
        issue_cnt = '0;
        for (int i = 0; i < LANES; i++) issue_cnt = issue_cnt + 32'(issue[i]);
    end

    assign left      = pending & ~issue;
    assign in_ready  = !flush && (!hold_valid || left == '0);
    assign accept    = in_valid && in_ready;
    assign iss_valid = issue;

    assign iss_rs1       = rs1_q;
    assign iss_rs2       = rs2_q;
    assign iss_rd        = rd_q;
    assign iss_reg_write = rw_q;
    assign iss_mem_read  = mr_q;
    assign iss_payload   = pl_q;

    // Hold register: load on accept, otherwise retire issued lanes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_valid <= 1'b0;
            pending    <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
            rw_q       <= '0;
            mr_q       <= '0;
            pl_q       <= '0;
        end else if (flush) begin
            hold_valid <= 1'b0;
            pending    <= '0;
        end else if (accept) begin
            hold_valid <= 1'b1;
            pending    <= in_lane_valid;
            rs1_q      <= in_rs1;
            rs2_q      <= in_rs2;
            rd_q       <= in_rd;
            rw_q       <= in_reg_write;
            mr_q       <= in_mem_read;
            pl_q       <= in_payload;
        end else begin
            pending <= left;
            if (left == '0) hold_valid <= 1'b0;
        end
    end

    // Scoreboard keeps counting through flush; a new load set wins over decrement.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREGS; r++) sb_cnt[r] <= '0;
        end else begin
            for (int r = 0; r < NREGS; r++) begin
                if (load_set[r])          sb_cnt[r] <= CNT_W'(LOAD_LAT);
                else if (sb_cnt[r] != '0) sb_cnt[r] <= sb_cnt[r] - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issued_insts <= '0;
            stall_cycles <= '0;
        end else begin
            issued_insts <= issued_insts + issue_cnt;
            if (hold_valid && pending != '0 && issue == '0 && !flush)
                stall_cycles <= stall_cycles + 32'd1;
        end
    end

endmodule

// File: doc/issue_ctrl_nway.md
# issue_ctrl_nway

Parametrised N-lane in-order issue controller for the superscalar core. It sits between the decode stage and the per-lane ID/EX registers. Each cycle it takes a decoded bundle of up to LANES instructions and issues the longest hazard-free in-order prefix. Unissued lanes are held and retried on later cycles. It generalises the fixed two-lane, load-only cross-lane stall to N lanes with intra-bundle RAW/WAW detection, a load-latency scoreboard, flush, and performance counters.

## Interface
- LANES, 2: lanes per bundle, 1..4.
- RA_W, 5: register address width.
- PAYLOAD_W, 32: opaque per-lane payload (instruction word), passed through unchanged.
- LOAD_LAT, 2: cycles a load's rd stays busy after the load's issue cycle, at least 1.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  bundle offered.
- in_ready  out  1  bundle accepted at this edge when in_valid && in_ready.
- in_lane_valid  in  LANES  per-lane occupancy; 0 marks a hole.
- in_rs1, in_rs2, in_rd  in  LANES*RA_W  packed; lane i is bits [i*RA_W +: RA_W].
- in_reg_write, in_mem_read  in  LANES  per-lane control.
- in_payload  in  LANES*PAYLOAD_W  packed payload.
- flush  in  1  discard held bundle.
- iss_valid  out  LANES  lanes issued this cycle.
- iss_rs1, iss_rs2, iss_rd, iss_reg_write, iss_mem_read, iss_payload  out  as inputs  held bundle fields, driven whether or not the lane issues.
- issued_insts  out  32  total lanes issued; wraps.
- stall_cycles  out  32  zero-issue cycles; wraps.

## Operation
- Hold register state: hold_valid, per-lane fields, pending[LANES].
- On acceptance the hold register loads the bundle and sets pending = in_lane_valid. An all-zero in_lane_valid still loads, then empties the next cycle.
- Register 0 is never a hazard source or target.
- Lane i is eligible when pending[i] and none of the following holds:
  - rs1 or rs2 or rd (rd only if reg_write) matches a busy scoreboard entry.
  - Some lower lane j issuing this cycle has reg_write[j], rd[j]!=0, and rd[j] equals rs1[i], rs2[i], or rd[i] when reg_write[i] (RAW/WAW).
- issue[i] = eligible[i] && every lower pending lane also issues (strict in-order). Non-pending lanes never block.
- iss_valid = issue when hold_valid && !flush; otherwise 0.
- At the edge, pending &= ~issue. hold_valid clears when pending becomes 0 and no new bundle is accepted.
- in_ready = !flush && (!hold_valid || (pending & ~issue)==0). A new bundle can therefore load in the same edge that the last held lanes issue.
- Scoreboard: one counter per register, width clog2(LOAD_LAT+1).
  - An issued lane with mem_read and rd!=0 sets cnt[rd]=LOAD_LAT.
  - All other nonzero counters decrement by 1 each cycle; set wins over decrement.
  - A register is busy while cnt!=0.
- flush: clears hold_valid and pending, forces iss_valid=0 and in_ready=0. The scoreboard keeps counting, because loads already issued still complete.
- Counters:
  - issued_insts += popcount(iss_valid).
  - stall_cycles += 1 when hold_valid && pending!=0 && iss_valid==0 && !flush.

## Timing
- Reset values: hold_valid=0, pending=0, iss_valid=0, in_ready=1, all scoreboard counters 0, issued_insts=0, stall_cycles=0. Held fields are 0.
- Latency: a bundle accepted at edge t is visible on iss_* during cycle t+1. Issue is combinational from the hold register and scoreboard.
- A load issued in cycle c blocks dependants through cycle c+LOAD_LAT. The earliest dependant issue is cycle c+LOAD_LAT+1.
- in_ready does not depend on in_valid (no combinational loop).
- Reset asserted mid-bundle drops the bundle and the scoreboard immediately.
- Deadlock-free: scoreboard entries always drain, and the lowest pending lane has no intra-bundle blocker.

## Test plan
- LANES=2, reset, bundle {add r1,r2,r3; add r4,r5,r6} -> iss_valid=2'b11 in cycle 1; in_ready=1; issued_insts=2.
- Bundle {add r3=r1+r2; sub r7=r3-r4} -> cycle 1: iss_valid=01, in_ready=0, stall_cycles unchanged. Cycle 2: iss_valid=10, in_ready=1, next bundle loads.
- LOAD_LAT=2: load r5 issues in cycle c, next bundle reads r5 -> iss_valid=0 in cycles c+1 and c+2 (stall_cycles +2), issues in cycle c+3.
- Bundle {add r0=...; add r9=r0+r0} and {load r0; use r0} -> both lanes issue in the same cycle; no scoreboard entry is set.
- flush while lane 1 is pending -> iss_valid=0 and in_ready=0 that cycle; hold empty next cycle; a busy load counter still decrements to 0 on schedule.
- LANES=4, in_lane_valid=4'b1010, lanes independent -> iss_valid=1010 in one cycle; issued_insts=2. With lane 1 blocked by the scoreboard, lane 3 is held (iss_valid=0000) until lane 1 issues.
